// File: rtl/neg_mono_pulse_gen.sv
// Edge-triggered monostable: counted output pulse, post-pulse holdoff, drop strobe.
// Build option: define RETRIGGER_EN to let a trigger during the pulse reload its length.
module neg_mono_pulse_gen #(
    parameter int CNT_W       = 16,
    parameter int HOLDOFF_LEN = 4,
    parameter int NEG_EDGE    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic [CNT_W-1:0] len,
    output logic             out,
    output logic             busy,
    output logic             drop
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PULSE   = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    localparam logic HAS_HOLD = (HOLDOFF_LEN > 0);
    localparam logic [CNT_W-1:0] HOLD_M1 =
        (HOLDOFF_LEN > 0) ? CNT_W'(HOLDOFF_LEN - 1) : '0;

`ifdef RETRIGGER_EN
    localparam logic RETRIG = 1'b1;
`else
    localparam logic RETRIG = 1'b0;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_m1;
    logic             sig_d;
    logic             armed;
    logic             trig;

    // Zero length is treated as a one-cycle pulse.
    assign len_m1 = (len == '0) ? '0 : len - CNT_W'(1);

    assign trig = armed & ((NEG_EDGE != 0) ? (sig_d & ~sig)
                                           : (~sig_d & sig));

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            drop  <= 1'b0;
            sig_d <= 1'b0;
            armed <= 1'b0;
        end else begin
            sig_d <= sig;
            armed <= 1'b1;
            drop  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state <= PULSE;
                        cnt   <= len_m1;
                        out   <= 1'b1;
                    end
                end
                PULSE: begin
                    if (trig && RETRIG) begin
                        cnt <= len_m1;
                    end else begin
                        drop <= trig;
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            out <= 1'b0;
                            if (HAS_HOLD) begin
                                state <= HOLDOFF;
                                cnt   <= HOLD_M1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                HOLDOFF: begin
                    drop <= trig;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule
